fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 104 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter letting NUM_REQ writers share one synchronous FIFO write port.
// Latency: one IDLE decision cycle before the first write; one bubble between grants.
// Backpressure: fifo_full holds the grant and beat count; a dropped req_valid releases it.
// Optional bursting: define FIFO_ARB_BURST_EN for multi-beat grants (req_last / MAX_BURST).
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_w_en,
  output logic [DATA_WIDTH-1:0]         fifo_data,
  input  logic                          fifo_full,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [3:0]      beat_cnt;

  logic [ID_W-1:0] pick;
  int              pick_idx;
  logic            cur_valid;
  logic            beat;
  logic            end_beat;
  logic [ID_W-1:0] next_ptr;

  // Round-robin search: first asserted request at or above rr_ptr, wrapping.
  // Walking the offsets downward lets the smallest offset win.
  always_comb begin
    pick     = rr_ptr;
    pick_idx = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pick_idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (req_valid[pick_idx]) pick = ID_W'(pick_idx);
    end
  end

  assign cur_valid = req_valid[grant_id];
  assign beat      = (state == GRANT) && cur_valid && !fifo_full;
  assign next_ptr  = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

`ifdef FIFO_ARB_BURST_EN
  assign end_beat = req_last[grant_id] || (({1'b0, beat_cnt} + 5'd1) == 5'(MAX_BURST));
`else
  // Every beat ends the grant; req_last has no meaning without bursting.
  logic unused_last;
  assign unused_last = ^req_last;
  assign end_beat    = 1'b1;
`endif

  // Write-side strobes are gated by reset so nothing reaches the FIFO during reset.
  always_comb begin
    fifo_w_en = rst_n && beat;
    req_ready = (rst_n && beat) ? (NUM_REQ'(1) << grant_id) : '0;
    fifo_data = (state == GRANT) ? req_data[grant_id*DATA_WIDTH +: DATA_WIDTH] : '0;
  end

  assign busy = (state == GRANT);

  // Arbitration FSM: IDLE picks a requester, GRANT streams its beats until end or withdraw.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            grant_id <= pick;
            beat_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (!cur_valid) begin
            state  <= IDLE;
            rr_ptr <= next_ptr;
          end else if (!fifo_full) begin
            if ({1'b0, beat_cnt} < 5'(MAX_BURST)) beat_cnt <= beat_cnt + 4'd1;
            if (end_beat) begin
              state  <= IDLE;
              rr_ptr <= next_ptr;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a transaction-level reference model.
// The model tracks only "who owns the port, where the round-robin pointer is, beats so far".
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NR-1:0] req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0] req_last;
  logic [NR-1:0] req_ready;
  logic          fifo_w_en;
  logic [DW-1:0] fifo_data;
  logic          fifo_full;
  logic [1:0]    grant_id;
  logic          busy;

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .fifo_w_en(fifo_w_en),
    .fifo_data(fifo_data), .fifo_full(fifo_full), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit chk_en  = 1'b0;

  logic [7:0] log_dat[$];
  int         log_gid[$];
  int         log_cyc[$];

  logic [7:0] exp_d[8];
  int         exp_g[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state: owner flag/id, round-robin start point, beats in this grant.
  bit m_busy  = 1'b0;
  int m_gid   = 0;
  int m_ptr   = 0;
  int m_beats = 0;
  bit m_found;
  int m_j;
  bit e_wen;
  bit m_end;
  logic [NR-1:0] e_rdy;
  logic [DW-1:0] e_dat;

  // Compare DUT outputs with the model each cycle, log writes, then advance the model.
  always @(negedge clk) begin
    if (chk_en) begin
      e_wen = rst_n && m_busy && req_valid[m_gid] && !fifo_full;
      e_rdy = e_wen ? (NR'(1) << m_gid) : '0;
      e_dat = m_busy ? req_data[m_gid*DW +: DW] : '0;
      chk("busy", 32'(busy), 32'(m_busy));
      chk("grant_id", 32'(grant_id), 32'(m_gid));
      chk("fifo_w_en", 32'(fifo_w_en), 32'(e_wen));
      chk("req_ready", 32'(req_ready), 32'(e_rdy));
      chk("fifo_data", 32'(fifo_data), 32'(e_dat));
      if (fifo_w_en === 1'b1) begin
        log_dat.push_back(fifo_data);
        log_gid.push_back(int'(grant_id));
        log_cyc.push_back(cyc);
      end
      if (!rst_n) begin
        m_busy = 0; m_gid = 0; m_ptr = 0; m_beats = 0;
      end else if (!m_busy) begin
        m_found = 0;
        for (int o = 0; o < NR; o++) begin
          m_j = (m_ptr + o) % NR;
          if (!m_found && req_valid[m_j]) begin
            m_found = 1; m_gid = m_j;
          end
        end
        if (m_found) begin
          m_busy = 1; m_beats = 0;
        end
      end else if (!req_valid[m_gid]) begin
        m_busy = 0; m_ptr = (m_gid + 1) % NR;
      end else if (!fifo_full) begin
        m_beats++;
`ifdef FIFO_ARB_BURST_EN
        m_end = req_last[m_gid] || (m_beats == MB);
`else
        m_end = 1'b1;
`endif
        if (m_end) begin
          m_busy = 0; m_ptr = (m_gid + 1) % NR;
        end
      end
    end
  end

  task automatic chk_log(input string tag, input int n);
    chk({tag, "_nwrites"}, 32'(log_dat.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      chk({tag, "_data"}, (i < log_dat.size()) ? 32'(log_dat[i]) : 32'hFFFF_FFFF, 32'(exp_d[i]));
      chk({tag, "_gid"}, (i < log_gid.size()) ? 32'(log_gid[i]) : 32'hFFFF_FFFF, 32'(exp_g[i]));
    end
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = '0; req_data = '0; req_last = '0; fifo_full = 1'b0;

    // Reset with every requester asking: nothing may be written, arbiter parked at 0.
    req_valid = 4'hF;
    tick;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_w_en", 32'(fifo_w_en), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    tick;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);

    // Round robin with all four asking: 0,1,2,3,0, one beat each, bubble in between.
    req_data = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
    req_last = 4'hF;
    log_dat.delete(); log_gid.delete(); log_cyc.delete();
    rst_n = 1'b1;
    repeat (10) tick;
    req_valid = '0;
    tick;
    exp_d = '{8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hD0, 8'h0, 8'h0, 8'h0};
    exp_g = '{0, 1, 2, 3, 0, 0, 0, 0};
    chk_log("rr", 5);
    for (int i = 1; i < log_cyc.size(); i++)
      chk("rr_gap", 32'(log_cyc[i] - log_cyc[i-1]), 32'd2);

    // Full stall on requester 2: three held cycles, then exactly one write of its word.
    do_reset;
    log_dat.delete(); log_gid.delete(); log_cyc.delete();
    req_valid = 4'b0100; fifo_full = 1'b1;
    tick;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_w_en", 32'(fifo_w_en), 32'd0);
      chk("stall_gid", 32'(grant_id), 32'd2);
      tick;
    end
    fifo_full = 1'b0;
    @(negedge clk);
    chk("stall_release_w_en", 32'(fifo_w_en), 32'd1);
    chk("stall_release_data", 32'(fifo_data), 32'hD2);
    tick;
    req_valid = '0;
    tick;
    exp_d = '{8'hD2, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0};
    exp_g = '{2, 0, 0, 0, 0, 0, 0, 0};
    chk_log("stall", 1);

    // Withdraw: requester 1 drops its request while granted; pointer must move past it.
    do_reset;
    log_dat.delete(); log_gid.delete(); log_cyc.delete();
    req_valid = 4'b0010;
    tick;
    req_valid = '0;
    @(negedge clk);
    chk("wd_w_en", 32'(fifo_w_en), 32'd0);
    chk("wd_busy", 32'(busy), 32'd1);
    tick;
    req_valid = 4'b0110;
    tick;
    @(negedge clk);
    chk("wd_next_gid", 32'(grant_id), 32'd2);
    tick;
    req_valid = '0;
    tick;
    exp_d = '{8'hD2, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0};
    exp_g = '{2, 0, 0, 0, 0, 0, 0, 0};
    chk_log("wd", 1);

    // Reset while requester 3 holds a grant: no write, restart searching from 0.
    do_reset;
    req_last = 4'b0111;
    req_valid = 4'b0100;
    tick;
    tick;
    req_valid = 4'b1000;
    tick;
    @(negedge clk);
    chk("mr_gid_before", 32'(grant_id), 32'd3);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mr_w_en", 32'(fifo_w_en), 32'd0);
    chk("mr_ready", 32'(req_ready), 32'd0);
    tick;
    rst_n = 1'b1;
    req_valid = 4'b1010;
    tick;
    @(negedge clk);
    chk("mr_next_gid", 32'(grant_id), 32'd1);
    tick;
    req_valid = '0;
    repeat (2) tick;

`ifdef FIFO_ARB_BURST_EN
    // Burst cap: requester 1 streams A0.. without last; four beats, then 2, then 1 again.
    do_reset;
    log_dat.delete(); log_gid.delete(); log_cyc.delete();
    req_last = 4'b0100;
    req_data = {8'hD3, 8'hC2, 8'hA0, 8'hD0};
    req_valid = 4'b0110;
    for (int i = 0; i < 9; i++) begin
      logic r1;
      @(negedge clk);
      r1 = req_ready[1];
      tick;
      if (r1) req_data[15:8] = req_data[15:8] + 8'd1;
    end
    req_valid = '0;
    repeat (2) tick;
    exp_d = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hC2, 8'hA4, 8'h0, 8'h0};
    exp_g = '{1, 1, 1, 1, 2, 1, 0, 0};
    chk_log("burst", 6);

    // Early last: requester 3 sends 11 then 22 with last; pointer wraps to 0.
    do_reset;
    log_dat.delete(); log_gid.delete(); log_cyc.delete();
    req_last = 4'b0000;
    req_data = {8'h11, 8'hD2, 8'hD1, 8'h55};
    req_valid = 4'b1000;
    tick;
    @(negedge clk);
    chk("last_beat1", 32'(fifo_data), 32'h11);
    tick;
    req_data[31:24] = 8'h22;
    req_last = 4'b1001;
    @(negedge clk);
    chk("last_beat2_w_en", 32'(fifo_w_en), 32'd1);
    tick;
    req_valid = 4'b1001;
    tick;
    @(negedge clk);
    chk("last_next_gid", 32'(grant_id), 32'd0);
    tick;
    req_valid = '0;
    tick;
    exp_d = '{8'h11, 8'h22, 8'h55, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0};
    exp_g = '{3, 3, 0, 0, 0, 0, 0, 0};
    chk_log("last", 3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
